// File: rtl/xrq_queue.sv
// xrq_queue: fetch-side request FIFO with full / almost-full back-pressure and a sticky overflow flag.
// Optional same-cycle bypass when empty is enabled by defining XRQ_BYPASS_EN.
module xrq_queue #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_vld_f1,
    input  logic [DATA_W-1:0]          wr_data_f1,
    output logic                       xrq_is_full,
    output logic                       xrq_is_almost_full,
    output logic                       xrq_out_vld,
    output logic [DATA_W-1:0]          xrq_out_data,
    input  logic                       xrq_out_rdy,
    output logic [$clog2(DEPTH):0]     xrq_cnt,
    output logic                       xrq_ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic is_empty;
    logic push_en;
    logic pop_en;

    // Flags come from the registered count only, so the producer may use them combinationally.
    assign is_empty           = (cnt_q == '0);
    assign xrq_is_full        = (cnt_q == FULL_LVL);
    assign xrq_is_almost_full = (cnt_q >= AFULL_LVL);
    assign xrq_cnt            = cnt_q;
    assign xrq_ovf_err        = ovf_q;

`ifdef XRQ_BYPASS_EN
    logic bypass_take;

    // An empty queue forwards the incoming strobe; if it is taken now it never touches storage.
    assign bypass_take  = is_empty && wr_vld_f1 && xrq_out_rdy;
    assign xrq_out_vld  = is_empty ? wr_vld_f1  : 1'b1;
    assign xrq_out_data = is_empty ? wr_data_f1 : mem[rd_ptr_q];
    assign push_en      = wr_vld_f1 && !xrq_is_full && !bypass_take;
    assign pop_en       = !is_empty && xrq_out_rdy;
`else
    assign xrq_out_vld  = !is_empty;
    assign xrq_out_data = mem[rd_ptr_q];
    assign push_en      = wr_vld_f1 && !xrq_is_full;
    assign pop_en       = xrq_out_vld && xrq_out_rdy;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // A strobe against a full queue is dropped; the error stays set until reset.
        if (wr_vld_f1 && xrq_is_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left unreset; the valid flag qualifies it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= wr_data_f1;
        end
    end

endmodule

// File: tb/tb_xrq_queue.sv
// Directed and scoreboard checks for xrq_queue (DEPTH=8, AFULL_TH=2).
// The bypass section runs only when XRQ_BYPASS_EN is defined; streaming and random phases assume the registered build.
module tb_xrq_queue;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 2;

    logic              clk;
    logic              rstn;
    logic              wr_vld_f1;
    logic [DATA_W-1:0] wr_data_f1;
    logic              xrq_is_full;
    logic              xrq_is_almost_full;
    logic              xrq_out_vld;
    logic [DATA_W-1:0] xrq_out_data;
    logic              xrq_out_rdy;
    logic [3:0]        xrq_cnt;
    logic              xrq_ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    xrq_queue #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .wr_vld_f1          (wr_vld_f1),
        .wr_data_f1         (wr_data_f1),
        .xrq_is_full        (xrq_is_full),
        .xrq_is_almost_full (xrq_is_almost_full),
        .xrq_out_vld        (xrq_out_vld),
        .xrq_out_data       (xrq_out_data),
        .xrq_out_rdy        (xrq_out_rdy),
        .xrq_cnt            (xrq_cnt),
        .xrq_ovf_err        (xrq_ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cnt"},   64'(xrq_cnt), 64'd0);
        check({tag, "_vld"},   64'(xrq_out_vld), 64'd0);
        check({tag, "_full"},  64'(xrq_is_full), 64'd0);
        check({tag, "_afull"}, 64'(xrq_is_almost_full), 64'd0);
        check({tag, "_ovf"},   64'(xrq_ovf_err), 64'd0);
    endtask

    initial begin
        logic [63:0] sb [$];
        int          popped;
        int          pushed;
        int          cyc;
        logic        do_push;

        rstn        = 1'b0;
        wr_vld_f1   = 1'b0;
        wr_data_f1  = '0;
        xrq_out_rdy = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rstn = 1'b1;
        tick();

        // Fill 1..8 with the consumer stalled.
        for (int i = 1; i <= DEPTH; i++) begin
            wr_vld_f1  = 1'b1;
            wr_data_f1 = 64'(i);
            tick();
            $display("push %0d: cnt=%0d afull=%0b full=%0b", i, xrq_cnt, xrq_is_almost_full, xrq_is_full);
            check("fill_cnt",   64'(xrq_cnt), 64'(i));
            check("fill_afull", 64'(xrq_is_almost_full), 64'(i >= DEPTH - AFULL_TH));
            check("fill_full",  64'(xrq_is_full), 64'(i == DEPTH));
            check("fill_head",  xrq_out_data, 64'd1);
        end
        wr_vld_f1 = 1'b0;
        check("fill_ovf", 64'(xrq_ovf_err), 64'd0);

        // Overflow push is dropped and the error sticks.
        wr_vld_f1  = 1'b1;
        wr_data_f1 = 64'hDEAD;
        tick();
        wr_vld_f1 = 1'b0;
        $display("overflow push 0xdead: cnt=%0d ovf=%0b", xrq_cnt, xrq_ovf_err);
        check("ovf_cnt", 64'(xrq_cnt), 64'd8);
        check("ovf_err", 64'(xrq_ovf_err), 64'd1);
        tick();
        check("ovf_sticky", 64'(xrq_ovf_err), 64'd1);

        // Drain returns 1..8 in order.
        xrq_out_rdy = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            $display("pop drain: data=%h vld=%0b", xrq_out_data, xrq_out_vld);
            check("drain_vld",  64'(xrq_out_vld), 64'd1);
            check("drain_data", xrq_out_data, 64'(i));
            tick();
        end
        xrq_out_rdy = 1'b0;
        check("drain_empty_vld", 64'(xrq_out_vld), 64'd0);
        check("drain_empty_cnt", 64'(xrq_cnt), 64'd0);
        check("drain_ovf_sticky", 64'(xrq_ovf_err), 64'd1);

        // Reset mid-operation with 5 entries buffered; clear must happen before any clock edge.
        for (int i = 0; i < 5; i++) begin
            wr_vld_f1  = 1'b1;
            wr_data_f1 = 64'h50 + 64'(i);
            tick();
        end
        wr_vld_f1 = 1'b0;
        check("midrst_pre_cnt", 64'(xrq_cnt), 64'd5);
        #2;
        rstn = 1'b0;
        #1;
        $display("async reset asserted: cnt=%0d vld=%0b ovf=%0b", xrq_cnt, xrq_out_vld, xrq_ovf_err);
        check_reset_state("midrst");
        tick();
        rstn = 1'b1;
        tick();
        wr_vld_f1  = 1'b1;
        wr_data_f1 = 64'hA5;
        tick();
        wr_vld_f1 = 1'b0;
        $display("push 0xa5 after reset: vld=%0b data=%h cnt=%0d", xrq_out_vld, xrq_out_data, xrq_cnt);
        check("postrst_vld",  64'(xrq_out_vld), 64'd1);
        check("postrst_data", xrq_out_data, 64'hA5);
        check("postrst_cnt",  64'(xrq_cnt), 64'd1);
        xrq_out_rdy = 1'b1;
        tick();
        xrq_out_rdy = 1'b0;
        check("postrst_drained", 64'(xrq_cnt), 64'd0);

`ifndef XRQ_BYPASS_EN
        // Streaming: each entry appears one cycle after its push, count stays at 1.
        xrq_out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_vld_f1  = 1'b1;
            wr_data_f1 = 64'h100 + 64'(i);
            tick();
            $display("stream %0d: data=%h cnt=%0d", i, xrq_out_data, xrq_cnt);
            check("stream_vld",  64'(xrq_out_vld), 64'd1);
            check("stream_data", xrq_out_data, 64'h100 + 64'(i));
            check("stream_cnt",  64'(xrq_cnt), 64'd1);
        end
        wr_vld_f1 = 1'b0;
        tick();
        xrq_out_rdy = 1'b0;
        check("stream_end_cnt", 64'(xrq_cnt), 64'd0);
        check("stream_end_vld", 64'(xrq_out_vld), 64'd0);

        // Random back-pressure against a queue model.
        popped = 0;
        pushed = 0;
        cyc    = 0;
        while (popped < 1000 && cyc < 20000) begin
            check("rand_cnt", 64'(xrq_cnt), 64'(sb.size()));
            check("rand_vld", 64'(xrq_out_vld), 64'(sb.size() != 0));
            xrq_out_rdy = 1'($urandom_range(0, 1));
            do_push     = (pushed < 1000) && !xrq_is_almost_full && ($urandom_range(0, 3) != 0);
            wr_vld_f1   = do_push;
            wr_data_f1  = {32'($urandom), 32'(pushed)};
            if (xrq_out_rdy && sb.size() != 0) begin
                check("rand_data", xrq_out_data, sb[0]);
                $display("rand pop %0d: data=%h", popped, xrq_out_data);
                void'(sb.pop_front());
                popped++;
            end
            if (do_push) begin
                sb.push_back(wr_data_f1);
                pushed++;
            end
            tick();
            cyc++;
        end
        wr_vld_f1   = 1'b0;
        xrq_out_rdy = 1'b0;
        check("rand_popped", 64'(popped), 64'd1000);
        check("rand_ovf",    64'(xrq_ovf_err), 64'd0);
`endif

`ifdef XRQ_BYPASS_EN
        // Bypass: empty queue with ready forwards in the same cycle and stores nothing.
        xrq_out_rdy = 1'b1;
        wr_vld_f1   = 1'b1;
        wr_data_f1  = 64'h42;
        #1;
        $display("bypass push 0x42 rdy=1: vld=%0b data=%h", xrq_out_vld, xrq_out_data);
        check("byp_vld",  64'(xrq_out_vld), 64'd1);
        check("byp_data", xrq_out_data, 64'h42);
        tick();
        wr_vld_f1 = 1'b0;
        check("byp_cnt", 64'(xrq_cnt), 64'd0);
        check("byp_vld_after", 64'(xrq_out_vld), 64'd0);
        xrq_out_rdy = 1'b0;
        wr_vld_f1   = 1'b1;
        wr_data_f1  = 64'h43;
        #1;
        check("byp_stall_vld",  64'(xrq_out_vld), 64'd1);
        check("byp_stall_data", xrq_out_data, 64'h43);
        tick();
        wr_vld_f1 = 1'b0;
        $display("bypass push 0x43 rdy=0: cnt=%0d data=%h", xrq_cnt, xrq_out_data);
        check("byp_store_cnt",  64'(xrq_cnt), 64'd1);
        check("byp_store_data", xrq_out_data, 64'h43);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
